afe_stream_sequencer: RTL and testbench

//  Streaming-mode scheduler for the AFE result registers. The main FSM enables it; it then owns the SPI read port.
//  On every AFE ADC-ready rising edge it reads NUM_CH consecutive result registers and writes each word to sample RAM.
//  It replaces the fixed sampling counter in the streaming loop with a real data-ready-driven frame scheduler.
//  It reports per-frame completion, overrun and SPI timeout to the CPU register block.

---
 rtl/afe_stream_sequencer_pkg.sv | 32 +++
 rtl/afe_rdy_sync.sv | 26 ++
 rtl/afe_stream_sequencer.sv | 125 ++++++++++++
 tb/tb_afe_stream_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_stream_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the AFE streaming
// frame scheduler.
package afe_stream_sequencer_pkg;

  localparam logic [7:0] AFE_RES0 = 8'h2A;
  localparam logic [7:0] AFE_RES1 = 8'h2B;
  localparam logic [7:0] AFE_RES2 = 8'h2C;
  localparam logic [7:0] AFE_RES3 = 8'h2D;
  localparam logic [7:0] AFE_RES4 = 8'h2E;
  localparam logic [7:0] AFE_RES5 = 8'h2F;
  localparam logic [7:0] AFE_DIAG = 8'h30;

  localparam int CH_W  = 3;
  localparam int TMO_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } seq_state_e;

  // Register addresses wrap modulo 256 on purpose.
  function automatic logic [7:0] chan_addr(
    input logic [7:0]      base,
    input logic [CH_W-1:0] ch
  );
    return base + {{(8-CH_W){1'b0}}, ch};
  endfunction

endpackage

// File: rtl/afe_rdy_sync.sv
// Two-flop synchronizer with rising-edge pulse for asynchronous AFE
// status pins (ADC_RDY, diag-end).
module afe_rdy_sync (
  input  logic clk,
  input  logic in_reset,
  input  logic in_pin,
  output logic out_rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (in_reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= in_pin;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign out_rise = s2_q & ~s3_q;

endmodule

// File: rtl/afe_stream_sequencer.sv
// Data-ready driven frame scheduler: reads NUM_CH AFE result registers
// over SPI on each ADC_RDY rise and streams them into sample RAM.
module afe_stream_sequencer
  import afe_stream_sequencer_pkg::*;
#(
  parameter int         NUM_CH    = 6,
  parameter logic [7:0] BASE_ADDR = AFE_RES0,
  parameter int         DATA_W    = 24,
  parameter int         RAM_AW    = 10,
  parameter int         TMO_CYC   = 4095
) (
  input  logic              clk,
  input  logic              in_reset,
  input  logic              in_stream_en,
  input  logic              in_afe_adc_rdy,
  input  logic              in_clear_flags,
  output logic              out_read_begin,
  output logic [7:0]        out_spi_addr,
  input  logic              in_read_write_done,
  input  logic [DATA_W-1:0] in_spi_rdata,
  output logic              out_ram_we,
  output logic [RAM_AW-1:0] out_ram_addr,
  output logic [DATA_W-1:0] out_ram_data,
  output logic              out_frame_done,
  output logic              out_overrun,
  output logic              out_timeout,
  output logic              out_busy
);

  seq_state_e        state_q;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] data_q;
  logic              rdy_evt;
  logic              last_ch;
  logic              tmo_hit;

  afe_rdy_sync u_rdy_sync (
    .clk      (clk),
    .in_reset (in_reset),
    .in_pin   (in_afe_adc_rdy),
    .out_rise (rdy_evt)
  );

  assign ch_d    = ch_q + 1'b1;
  assign ptr_d   = ptr_q + 1'b1;
  assign tmo_d   = tmo_q + 1'b1;
  assign last_ch = (ch_q == CH_W'(NUM_CH - 1));
  // A done pulse in the expiry cycle still counts as success.
  assign tmo_hit = (state_q == ST_WAIT) && !in_read_write_done
                && (tmo_q == TMO_W'(TMO_CYC));
  assign out_busy = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      ptr_q          <= '0;
      tmo_q          <= '0;
      data_q         <= '0;
      out_read_begin <= 1'b0;
      out_spi_addr   <= '0;
      out_ram_we     <= 1'b0;
      out_ram_addr   <= '0;
      out_ram_data   <= '0;
      out_frame_done <= 1'b0;
      out_overrun    <= 1'b0;
      out_timeout    <= 1'b0;
    end else begin
      out_read_begin <= 1'b0;
      out_ram_we     <= 1'b0;
      out_frame_done <= 1'b0;

      if (rdy_evt && (state_q != ST_IDLE)) out_overrun <= 1'b1;
      else if (in_clear_flags)             out_overrun <= 1'b0;

      if (tmo_hit)             out_timeout <= 1'b1;
      else if (in_clear_flags) out_timeout <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (rdy_evt && in_stream_en) begin
            ch_q    <= '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          out_read_begin <= 1'b1;
          out_spi_addr   <= chan_addr(BASE_ADDR, ch_q);
          tmo_q          <= '0;
          state_q        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (in_read_write_done) begin
            data_q  <= in_spi_rdata;
            state_q <= ST_STORE;
          end else if (tmo_hit) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_STORE: begin
          out_ram_we   <= 1'b1;
          out_ram_addr <= ptr_q;
          out_ram_data <= data_q;
          ptr_q        <= ptr_d;
          if (last_ch)            state_q <= ST_DONE;
          else if (!in_stream_en) state_q <= ST_IDLE;
          else begin
            ch_q    <= ch_d;
            state_q <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          out_frame_done <= 1'b1;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afe_stream_sequencer.sv
// Randomized bench for afe_stream_sequencer with a transaction-level
// SPI responder and a frame/RAM-pointer reference model.
module tb_afe_stream_sequencer;

  localparam int NCH  = 6;
  localparam int BASE = 'h2A;
  localparam int RAMD = 1024;
  localparam int TMO  = 4095;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic        clk = 1'b0;
  logic        in_reset;
  logic        in_stream_en;
  logic        in_afe_adc_rdy;
  logic        in_clear_flags;
  logic        out_read_begin;
  logic [7:0]  out_spi_addr;
  logic        in_read_write_done;
  logic [23:0] in_spi_rdata;
  logic        out_ram_we;
  logic [9:0]  out_ram_addr;
  logic [23:0] out_ram_data;
  logic        out_frame_done;
  logic        out_overrun;
  logic        out_timeout;
  logic        out_busy;

  afe_stream_sequencer dut (
    .clk                (clk),
    .in_reset           (in_reset),
    .in_stream_en       (in_stream_en),
    .in_afe_adc_rdy     (in_afe_adc_rdy),
    .in_clear_flags     (in_clear_flags),
    .out_read_begin     (out_read_begin),
    .out_spi_addr       (out_spi_addr),
    .in_read_write_done (in_read_write_done),
    .in_spi_rdata       (in_spi_rdata),
    .out_ram_we         (out_ram_we),
    .out_ram_addr       (out_ram_addr),
    .out_ram_data       (out_ram_data),
    .out_frame_done     (out_frame_done),
    .out_overrun        (out_overrun),
    .out_timeout        (out_timeout),
    .out_busy           (out_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int  rd_q[$];
  int  rd_cyc[$];
  wr_t wr_q[$];
  int  spi_q[$];
  int  fd_cnt  = 0;
  int  tmo_cyc = 0;
  bit  tmo_prev = 1'b0;

  int hang_ch = -1;
  int dly_lo  = 0;
  int dly_hi  = 4;
  int m_ptr   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_read_begin) begin
      rd_q.push_back(int'(out_spi_addr));
      rd_cyc.push_back(cyc);
    end
    if (out_ram_we) begin
      wr_q.push_back('{int'(out_ram_addr), int'(out_ram_data)});
    end
    if (out_frame_done) fd_cnt++;
    if (out_timeout && !tmo_prev) tmo_cyc = cyc;
    tmo_prev = out_timeout;
  end

  // SPI slave: answers each read after a random delay unless hung.
  initial begin
    int a, d;
    logic [23:0] w;
    in_read_write_done = 1'b0;
    in_spi_rdata = '0;
    forever begin
      @(negedge clk);
      if (out_read_begin) begin
        a = int'(out_spi_addr);
        if (a - BASE != hang_ch) begin
          d = $urandom_range(dly_hi, dly_lo);
          repeat (d) @(negedge clk);
          w = 24'($urandom);
          spi_q.push_back(int'(w));
          in_spi_rdata = w;
          in_read_write_done = 1'b1;
          @(negedge clk);
          in_read_write_done = 1'b0;
        end
      end
    end
  end

  task automatic clr_q();
    rd_q.delete();
    rd_cyc.delete();
    wr_q.delete();
    spi_q.delete();
    fd_cnt = 0;
  endtask

  task automatic pin_pulse(input int hl);
    in_afe_adc_rdy = 1'b1;
    repeat (hl) @(negedge clk);
    in_afe_adc_rdy = 1'b0;
  endtask

  task automatic wait_rd(input int n, input int budget);
    int k = 0;
    while (rd_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("wait_rd", rd_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (out_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("wait_idle", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clear();
    in_clear_flags = 1'b1;
    @(negedge clk);
    in_clear_flags = 1'b0;
    @(negedge clk);
  endtask

  // Compares one frame's traffic with the model and advances its pointer.
  task automatic check_frame(input int nrd, input int nwr,
                             input int fd_exp, input int ovr_exp,
                             input int tmo_exp);
    chk("rd_cnt", rd_q.size(), nrd);
    for (int k = 0; k < nrd && k < rd_q.size(); k++)
      chk("rd_addr", rd_q[k], (BASE + k) % 256);
    chk("wr_cnt", wr_q.size(), nwr);
    for (int k = 0; k < nwr && k < wr_q.size(); k++) begin
      chk("wr_addr", wr_q[k].addr, (m_ptr + k) % RAMD);
      chk("wr_data", wr_q[k].data, (k < spi_q.size()) ? spi_q[k] : -1);
    end
    chk("frame_done", fd_cnt, fd_exp);
    chk("overrun", int'(out_overrun), ovr_exp);
    chk("timeout", int'(out_timeout), tmo_exp);
    chk("busy_end", int'(out_busy), 0);
    m_ptr = (m_ptr + nwr) % RAMD;
  endtask

  task automatic run_frame(input bit inj);
    int c0;
    clr_q();
    c0 = cyc;
    pin_pulse($urandom_range(5, 3));
    if (inj) begin
      wait_rd(3, 200);
      in_afe_adc_rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_clear_flags = 1'b1;
      @(negedge clk);
      in_clear_flags = 1'b0;
      in_afe_adc_rdy = 1'b0;
    end
    wait_idle(400);
    if (rd_cyc.size() > 0) chk("latency", rd_cyc[0] - c0, 4);
    check_frame(NCH, NCH, 1, int'(inj), 0);
    if (inj) begin
      pulse_clear();
      chk("ovr_clear", int'(out_overrun), 0);
    end
    repeat ($urandom_range(4, 1)) @(negedge clk);
  endtask

  initial begin
    in_reset       = 1'b1;
    in_stream_en   = 1'b1;
    in_afe_adc_rdy = 1'b0;
    in_clear_flags = 1'b0;
    repeat (3) @(negedge clk);
    in_reset = 1'b0;
    @(negedge clk);

    chk("rst_begin", int'(out_read_begin), 0);
    chk("rst_addr", int'(out_spi_addr), 0);
    chk("rst_we", int'(out_ram_we), 0);
    chk("rst_ram_addr", int'(out_ram_addr), 0);
    chk("rst_fd", int'(out_frame_done), 0);
    chk("rst_ovr", int'(out_overrun), 0);
    chk("rst_tmo", int'(out_timeout), 0);
    chk("rst_busy", int'(out_busy), 0);

    // Stray done while idle must not write.
    clr_q();
    in_read_write_done = 1'b1;
    @(negedge clk);
    in_read_write_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_done_wr", wr_q.size(), 0);

    // Randomized frames; enough writes to wrap the RAM pointer.
    for (int f = 0; f < 180; f++)
      run_frame($urandom_range(5, 0) == 0);

    // Timeout on channel 3.
    hang_ch = 3;
    clr_q();
    pin_pulse(4);
    wait_idle(5000);
    check_frame(4, 3, 0, 0, 1);
    if (rd_cyc.size() > 3) chk("tmo_latency", tmo_cyc - rd_cyc[3], TMO + 1);
    hang_ch = -1;
    pulse_clear();
    chk("tmo_clear", int'(out_timeout), 0);
    run_frame(1'b0);

    // Enable dropped while waiting on channel 1.
    dly_lo = 4;
    dly_hi = 4;
    clr_q();
    pin_pulse(4);
    wait_rd(2, 100);
    in_stream_en = 1'b0;
    wait_idle(200);
    check_frame(2, 2, 0, 0, 0);
    clr_q();
    pin_pulse(4);
    repeat (20) @(negedge clk);
    chk("dis_rd_cnt", rd_q.size(), 0);
    chk("dis_busy", int'(out_busy), 0);
    in_stream_en = 1'b1;

    // Reset during WAIT on channel 1; the late done is discarded.
    dly_lo = 6;
    dly_hi = 6;
    clr_q();
    pin_pulse(4);
    wait_rd(2, 100);
    in_reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(out_busy), 0);
    chk("mid_rst_begin", int'(out_read_begin), 0);
    chk("mid_rst_addr", int'(out_spi_addr), 0);
    chk("mid_rst_ram_addr", int'(out_ram_addr), 0);
    chk("mid_rst_data", int'(out_ram_data), 0);
    in_reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_rst_wr_cnt", wr_q.size(), 1);
    chk("mid_rst_we", int'(out_ram_we), 0);
    chk("mid_rst_fd", fd_cnt, 0);
    m_ptr  = 0;
    dly_lo = 0;
    dly_hi = 4;
    run_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
